fpnew_opgroup_vec_sequencer: RTL and testbench

//  Successor slice front-end for variable-latency opgroups (e.g. DIVSQRT).

---
 rtl/fpnew_pkg.sv | 59 +++++
 rtl/fpnew_vseq_lane_buffer.sv | 29 ++
 rtl/fpnew_opgroup_vec_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_fpnew_opgroup_vec_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared types and helpers for the FP slice front-ends: formats, rounding
// modes, operations, status flags and the vector sequencer state encoding.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } vseq_state_e;

  // Bit width of one value in the given format.
  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP64:          return 64;
      FP32:          return 32;
      FP16, FP16ALT: return 16;
      FP8:           return 8;
      default:       return 32;
    endcase
  endfunction

  // Number of lanes that fit in a datapath; a scalar-only slice has one lane.
  function automatic int unsigned num_lanes(int unsigned width, fp_format_e fmt, logic vec);
    int unsigned n;
    n = vec ? (width / fp_width(fmt)) : 1;
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/fpnew_vseq_lane_buffer.sv
// Holds the result and status returned by one lane until the merged result
// has been consumed. Clear wins over capture so a flushed op leaves nothing.
module fpnew_vseq_lane_buffer
  import fpnew_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 capture_i,
  input  logic [DataWidth-1:0] result_i,
  input  status_t              status_i,
  output logic [DataWidth-1:0] result_o,
  output status_t              status_o
);

  // Capture on the lane's result handshake, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      result_o <= '0;
      status_o <= '0;
    end else if (capture_i) begin
      result_o <= result_i;
      status_o <= status_i;
    end
  end

endmodule

// File: rtl/fpnew_opgroup_vec_sequencer.sv
// Front-end for variable-latency opgroups. Accepts one scalar or vector op,
// issues each active lane to its own external unit, gathers the lane results
// in any order and emits a single merged result with NaN-boxed/sign-extended
// filler for unused lanes and OR-collapsed status.
// Optional feature: define FPNEW_VSEQ_LANE_MASK_EN to honour lane_mask_i for
// partial vectors; without it a vector op activates every lane.
module fpnew_opgroup_vec_sequencer
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat      = FP32,
  parameter int unsigned Width         = 32,
  parameter logic        EnableVectors = 1'b1,
  parameter int unsigned NumOperands   = 2,
  parameter type         TagType       = logic,
  localparam int unsigned FP_WIDTH     = fp_width(FpFormat),
  localparam int unsigned NUM_LANES    = num_lanes(Width, FpFormat, EnableVectors)
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic [NumOperands-1:0][Width-1:0]                 operands_i,
  input  roundmode_e                                        rnd_mode_i,
  input  operation_e                                        op_i,
  input  logic                                              op_mod_i,
  input  logic                                              vectorial_op_i,
  input  logic [NUM_LANES-1:0]                              lane_mask_i,
  input  TagType                                            tag_i,
  input  logic                                              in_valid_i,
  output logic                                              in_ready_o,
  input  logic                                              flush_i,
  output logic [NUM_LANES-1:0]                              lane_valid_o,
  input  logic [NUM_LANES-1:0]                              lane_ready_i,
  output logic [NUM_LANES-1:0][NumOperands-1:0][FP_WIDTH-1:0] lane_operands_o,
  output roundmode_e                                        lane_rnd_mode_o,
  output operation_e                                        lane_op_o,
  output logic                                              lane_op_mod_o,
  output logic                                              lane_flush_o,
  input  logic [NUM_LANES-1:0]                              lane_res_valid_i,
  output logic [NUM_LANES-1:0]                              lane_res_ready_o,
  input  logic [NUM_LANES-1:0][FP_WIDTH-1:0]                lane_result_i,
  input  status_t [NUM_LANES-1:0]                           lane_status_i,
  input  logic [NUM_LANES-1:0]                              lane_ext_bit_i,
  output logic [Width-1:0]                                  result_o,
  output status_t                                           status_o,
  output logic                                              extension_bit_o,
  output TagType                                            tag_o,
  output logic                                              out_valid_o,
  input  logic                                              out_ready_i,
  output logic                                              busy_o
);

  vseq_state_e state_q, state_d;

  logic [NUM_LANES-1:0] pend_issue_q, pend_issue_d;
  logic [NUM_LANES-1:0] pend_res_q, pend_res_d;
  logic [NUM_LANES-1:0] act_q, act_d;
  logic [NUM_LANES-1:0] new_act;
  logic [NUM_LANES-1:0] res_hs;
  logic                 accept;
  logic                 clear_buf;
  logic                 ext0_q;
  TagType               tag_q;

  logic [NUM_LANES-1:0][FP_WIDTH-1:0] buf_result;
  status_t [NUM_LANES-1:0]            buf_status;

  // Some input bits only matter in certain configurations (lane mask without
  // the mask feature, ext bits of lanes above 0, spare operand bits); they are
  // collected here so every input bit has a reader.
  logic unused_inputs;
  assign unused_inputs = ^{lane_mask_i, lane_ext_bit_i, operands_i};

  // Lanes taking part in the incoming op; lane 0 is always active.
  always_comb begin
    new_act    = '0;
    new_act[0] = 1'b1;
    if (vectorial_op_i && EnableVectors) begin
`ifdef FPNEW_VSEQ_LANE_MASK_EN
      new_act = lane_mask_i;
      new_act[0] = 1'b1;
`else
      new_act = '1;
`endif
    end
  end

  // Next-state, lane handshakes and upstream/downstream handshakes; flush
  // overrides everything else in the same cycle.
  always_comb begin
    state_d          = state_q;
    pend_issue_d     = pend_issue_q;
    pend_res_d       = pend_res_q;
    act_d            = act_q;
    in_ready_o       = 1'b0;
    out_valid_o      = 1'b0;
    lane_valid_o     = '0;
    lane_res_ready_o = '0;
    res_hs           = '0;
    accept           = 1'b0;
    clear_buf        = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_o = ~rst_i & ~flush_i;
        if (in_valid_i && !rst_i && !flush_i) begin
          accept       = 1'b1;
          clear_buf    = 1'b1;
          act_d        = new_act;
          pend_issue_d = new_act;
          pend_res_d   = new_act;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (!flush_i) begin
          lane_valid_o     = pend_issue_q;
          lane_res_ready_o = pend_res_q;
          res_hs           = pend_res_q & lane_res_valid_i;
          pend_issue_d     = pend_issue_q & ~lane_ready_i;
          pend_res_d       = pend_res_q & ~res_hs;
          if ((pend_issue_d == '0) && (pend_res_d == '0)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        out_valid_o = ~flush_i;
        if (out_ready_i && !flush_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d      = IDLE;
      pend_issue_d = '0;
      pend_res_d   = '0;
      act_d        = '0;
      clear_buf    = 1'b1;
    end
  end

  // State and lane bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pend_issue_q <= '0;
      pend_res_q   <= '0;
      act_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_issue_q <= pend_issue_d;
      pend_res_q   <= pend_res_d;
      act_q        <= act_d;
    end
  end

  // Operands, controls and tag are latched at accept and held for the lanes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_operands_o <= '0;
      lane_rnd_mode_o <= RNE;
      lane_op_o       <= FMADD;
      lane_op_mod_o   <= 1'b0;
      tag_q           <= '0;
    end else if (accept) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        for (int unsigned k = 0; k < NumOperands; k++) begin
          lane_operands_o[l][k] <= operands_i[k][l*FP_WIDTH +: FP_WIDTH];
        end
      end
      lane_rnd_mode_o <= rnd_mode_i;
      lane_op_o       <= op_i;
      lane_op_mod_o   <= op_mod_i;
      tag_q           <= tag_i;
    end
  end

  // Lane 0's extension bit decides the filler for unused lanes and upper bits.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_buf) begin
      ext0_q <= 1'b0;
    end else if (res_hs[0]) begin
      ext0_q <= lane_ext_bit_i[0];
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : gen_lane_buf
    fpnew_vseq_lane_buffer #(
      .DataWidth (FP_WIDTH)
    ) i_lane_buffer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (clear_buf),
      .capture_i (res_hs[l]),
      .result_i  (lane_result_i[l]),
      .status_i  (lane_status_i[l]),
      .result_o  (buf_result[l]),
      .status_o  (buf_status[l])
    );
  end

  // Merge: active lanes in index order, everything else filled with ext0;
  // only active lanes contribute status.
  always_comb begin
    result_o = {Width{ext0_q}};
    status_o = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (act_q[l]) begin
        result_o[l*FP_WIDTH +: FP_WIDTH] = buf_result[l];
        status_o = status_t'(status_o | buf_status[l]);
      end
    end
  end

  assign extension_bit_o = ext0_q;
  assign tag_o           = tag_q;
  assign lane_flush_o    = flush_i;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_fpnew_opgroup_vec_sequencer.sv
// Self-checking bench for fpnew_opgroup_vec_sequencer (FP16, 72-bit slice,
// four lanes plus 8 spare upper bits). Lane units are emulated with per-lane
// ready delays and latencies; expectations come from a lane-level model.
module tb_fpnew_opgroup_vec_sequencer;
  import fpnew_pkg::*;

  localparam int NL     = 4;
  localparam int FW     = 16;
  localparam int W      = 72;
  localparam int NO     = 2;
  localparam int MAXCYC = 200;

  typedef logic [127:0] cv_t;

  logic clk = 1'b0;
  logic rst;
  logic [NO-1:0][W-1:0] operands;
  roundmode_e rnd_mode;
  operation_e op;
  logic op_mod, vec;
  logic [NL-1:0] lane_mask;
  logic [7:0] tag;
  logic in_valid, in_ready, flush;
  logic [NL-1:0] lane_valid, lane_ready;
  logic [NL-1:0][NO-1:0][FW-1:0] lane_operands;
  roundmode_e lane_rnd;
  operation_e lane_op;
  logic lane_op_mod, lane_flush;
  logic [NL-1:0] lane_res_valid, lane_res_ready;
  logic [NL-1:0][FW-1:0] lane_result;
  status_t [NL-1:0] lane_status;
  logic [NL-1:0] lane_ext;
  logic [W-1:0] result;
  status_t status;
  logic ext_bit;
  logic [7:0] tag_out;
  logic out_valid, out_ready, busy;

  int tests = 0;
  int fails = 0;

  int wait_c[NL];
  int lat[NL];
  logic [FW-1:0] res_v[NL];
  logic [4:0] st_v[NL];
  logic ext_v;

  bit issued[NL];
  bit done[NL];
  int wcnt[NL];
  int lcnt[NL];

  logic [NL-1:0] exp_act;
  logic [W-1:0] exp_res;
  logic [4:0] exp_st;
  int exp_done;
  logic [NL-1:0][NO-1:0][FW-1:0] exp_ops;
  logic [7:0] exp_tag;
  logic [7:0] exp_ctrl;

  fpnew_opgroup_vec_sequencer #(
    .FpFormat      (FP16),
    .Width         (W),
    .EnableVectors (1'b1),
    .NumOperands   (NO),
    .TagType       (logic [7:0])
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .operands_i       (operands),
    .rnd_mode_i       (rnd_mode),
    .op_i             (op),
    .op_mod_i         (op_mod),
    .vectorial_op_i   (vec),
    .lane_mask_i      (lane_mask),
    .tag_i            (tag),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .flush_i          (flush),
    .lane_valid_o     (lane_valid),
    .lane_ready_i     (lane_ready),
    .lane_operands_o  (lane_operands),
    .lane_rnd_mode_o  (lane_rnd),
    .lane_op_o        (lane_op),
    .lane_op_mod_o    (lane_op_mod),
    .lane_flush_o     (lane_flush),
    .lane_res_valid_i (lane_res_valid),
    .lane_res_ready_o (lane_res_ready),
    .lane_result_i    (lane_result),
    .lane_status_i    (lane_status),
    .lane_ext_bit_i   (lane_ext),
    .result_o         (result),
    .status_o         (status),
    .extension_bit_o  (ext_bit),
    .tag_o            (tag_out),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  // Hard stop in case the stimulus itself gets stuck.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 500000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input cv_t obs, input cv_t exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h required %0h", name, obs, exp);
    end
  endtask

  task automatic laneIdle();
    lane_ready     = '0;
    lane_res_valid = '0;
    lane_result    = '0;
    lane_status    = '0;
    lane_ext       = '0;
  endtask

  task automatic scrambleInputs();
    for (int i = 0; i < NO; i++)
      for (int j = 0; j < W; j++)
        operands[i][j] = 1'($urandom);
    tag = 8'($urandom);
  endtask

  task automatic randomOp();
    scrambleInputs();
    vec       = 1'($urandom);
    lane_mask = 4'($urandom);
    rnd_mode  = roundmode_e'(3'($urandom_range(0, 4)));
    op        = operation_e'(4'($urandom_range(0, 14)));
    op_mod    = 1'($urandom);
    ext_v     = 1'($urandom);
    for (int l = 0; l < NL; l++) begin
      wait_c[l] = $urandom_range(0, 3);
      lat[l]    = $urandom_range(0, 5);
      res_v[l]  = 16'($urandom);
      st_v[l]   = 5'($urandom);
    end
  endtask

  // One cycle of the emulated lane units; inactive lanes spam results that
  // must be ignored.
  task automatic laneStep();
    lane_ext = ~{NL{ext_v}};
    for (int l = 0; l < NL; l++) begin
      lane_ready[l]     = 1'b0;
      lane_res_valid[l] = 1'b0;
      lane_result[l]    = 16'($urandom);
      lane_status[l]    = status_t'(5'($urandom));
      if (!exp_act[l]) begin
        lane_ready[l]     = 1'b1;
        lane_res_valid[l] = 1'b1;
        lane_status[l]    = status_t'(5'b11111);
      end else begin
        if (!issued[l]) begin
          if (lane_valid[l]) begin
            if (wcnt[l] > 0) wcnt[l]--;
            else begin
              lane_ready[l] = 1'b1;
              issued[l]     = 1'b1;
              lcnt[l]       = lat[l];
            end
          end
        end else if (lcnt[l] > 0) begin
          lcnt[l]--;
        end
        if (issued[l] && lcnt[l] == 0 && !done[l]) begin
          lane_res_valid[l] = 1'b1;
          lane_result[l]    = res_v[l];
          lane_status[l]    = status_t'(st_v[l]);
          if (l == 0) lane_ext[0] = ext_v;
          if (lane_res_ready[l]) done[l] = 1'b1;
        end
      end
    end
  endtask

  // Builds the expected outcome from the lane settings, then accepts the op
  // and checks the first issue cycle. Returns at the negedge of cycle 1.
  task automatic startOp();
`ifdef FPNEW_VSEQ_LANE_MASK_EN
    exp_act = vec ? (lane_mask | 4'b0001) : 4'b0001;
`else
    exp_act = vec ? 4'b1111 : 4'b0001;
`endif
    exp_res  = {W{ext_v}};
    exp_st   = '0;
    exp_done = 0;
    for (int l = 0; l < NL; l++) begin
      issued[l] = 1'b0;
      done[l]   = 1'b0;
      wcnt[l]   = wait_c[l];
      lcnt[l]   = 0;
      if (exp_act[l]) begin
        exp_res[l*FW +: FW] = res_v[l];
        exp_st = exp_st | st_v[l];
        if (wait_c[l] + lat[l] + 2 > exp_done) exp_done = wait_c[l] + lat[l] + 2;
      end
      for (int k = 0; k < NO; k++) exp_ops[l][k] = operands[k][l*FW +: FW];
    end
    exp_tag  = tag;
    exp_ctrl = {rnd_mode, op, op_mod};
    laneIdle();
    in_valid = 1'b1;
    checkOutput("accept_in_ready", cv_t'(in_ready), cv_t'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    scrambleInputs();
    checkOutput("issue_lane_valid", cv_t'(lane_valid), cv_t'(exp_act));
    checkOutput("issue_operands", cv_t'(lane_operands), cv_t'(exp_ops));
    checkOutput("issue_ctrl", cv_t'({lane_rnd, lane_op, lane_op_mod}), cv_t'(exp_ctrl));
    checkOutput("issue_busy", cv_t'(busy), cv_t'(1));
  endtask

  // Full op: accept, run lanes until the merged result appears, hold it for
  // 'hold' cycles with out_ready low, then consume it.
  task automatic applyStimulus(input int hold);
    int cyc;
    startOp();
    cyc = 1;
    while (!out_valid && cyc < MAXCYC) begin
      laneStep();
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    laneIdle();
    checkOutput("done_cycle", cv_t'(cyc), cv_t'(exp_done));
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      checkOutput("hold_result", cv_t'(result), cv_t'(exp_res));
      checkOutput("hold_tag", cv_t'(tag_out), cv_t'(exp_tag));
      checkOutput("hold_in_ready", cv_t'(in_ready), cv_t'(0));
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("out_valid", cv_t'(out_valid), cv_t'(1));
    checkOutput("result", cv_t'(result), cv_t'(exp_res));
    checkOutput("status", cv_t'(status), cv_t'(exp_st));
    checkOutput("ext_bit", cv_t'(ext_bit), cv_t'(ext_v));
    checkOutput("tag", cv_t'(tag_out), cv_t'(exp_tag));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("back_to_idle", cv_t'({busy, out_valid, in_ready}), cv_t'(3'b001));
  endtask

  // Flush with two lane results already buffered and two lanes still out.
  task automatic flushTest();
    randomOp();
    vec       = 1'b1;
    lane_mask = 4'b1111;
    for (int l = 0; l < NL; l++) begin
      wait_c[l] = 0;
      lat[l]    = (l < 2) ? 1 : 30;
      st_v[l]   = 5'b11111;
    end
    startOp();
    for (int c = 1; c < 5; c++) begin
      laneStep();
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("flush_pre_busy", cv_t'(busy), cv_t'(1));
    laneIdle();
    flush = 1'b1;
    #1;
    checkOutput("flush_out_valid", cv_t'(out_valid), cv_t'(0));
    checkOutput("flush_lane_flush", cv_t'(lane_flush), cv_t'(1));
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush_idle", cv_t'({busy, out_valid, in_ready}), cv_t'(3'b001));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("flush_quiet", cv_t'({busy, out_valid}), cv_t'(0));
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    ext_v     = 1'b0;
    exp_act   = 4'b0001;
    randomOp();
    laneIdle();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", cv_t'(in_ready), cv_t'(0));
    checkOutput("reset_flags", cv_t'({busy, out_valid}), cv_t'(0));
    checkOutput("reset_result", cv_t'(result), cv_t'(0));
    checkOutput("reset_status", cv_t'(status), cv_t'(0));
    rst = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", cv_t'(in_ready), cv_t'(1));
    @(negedge clk);

    $display("[TB] scalar op, lane 0 latency 4");
    randomOp();
    vec = 1'b0; wait_c[0] = 0; lat[0] = 4;
    applyStimulus(0);

    $display("[TB] full vector, lanes return 3,1,0,2");
    randomOp();
    vec = 1'b1; lane_mask = 4'b1111;
    for (int l = 0; l < NL; l++) wait_c[l] = 0;
    lat[3] = 1; lat[1] = 2; lat[0] = 3; lat[2] = 4;
    applyStimulus(1);

    $display("[TB] vector mask 0100, ext0 set, lane 1 NV");
    randomOp();
    vec = 1'b1; lane_mask = 4'b0100; ext_v = 1'b1;
    st_v[0] = 5'b00001; st_v[1] = 5'b10000; st_v[2] = 5'b00100; st_v[3] = 5'b00000;
    applyStimulus(0);

    $display("[TB] vector mask 0000");
    randomOp();
    vec = 1'b1; lane_mask = 4'b0000;
    applyStimulus(0);

    $display("[TB] lane 1 ready held low for 5 cycles");
    randomOp();
    vec = 1'b1; lane_mask = 4'b1111;
    for (int l = 0; l < NL; l++) begin
      wait_c[l] = 0;
      lat[l]    = 1;
    end
    wait_c[1] = 5;
    applyStimulus(0);

    $display("[TB] flush while busy, then a clean op");
    flushTest();
    randomOp();
    vec = 1'b1; lane_mask = 4'b1111;
    for (int l = 0; l < NL; l++) st_v[l] = 5'b00000;
    applyStimulus(0);

    $display("[TB] out_ready held low 3 cycles");
    randomOp();
    applyStimulus(3);

    $display("[TB] randomized ops");
    for (int n = 0; n < 25; n++) begin
      randomOp();
      applyStimulus($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
